// File: rtl/obi_arb_pkg.sv
// Shared types for the two-to-one OBI memory arbiter.
// Requester ids travel through the in-flight FIFO so responses find their way home.
package obi_arb_pkg;

    typedef logic id_t;

    localparam id_t ID_INSTR = 1'b0;
    localparam id_t ID_DATA  = 1'b1;

endpackage

// File: rtl/obi_if.sv
// OBI address-phase and response-phase bundles.
// Request slave: arbiter receives req/we/be/addr/wdata and drives gnt.
interface obi_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  gnt;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;

    modport master (output req, we, be, addr, wdata, input gnt);
    modport slave  (input req, we, be, addr, wdata, output gnt);
endinterface

interface obi_rsp_if #(
    parameter int DATA_W = 32
);
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    // slave drives the response toward a requester; master receives it from memory
    modport slave  (output rvalid, rdata);
    modport master (input rvalid, rdata);
endinterface

// File: rtl/obi_id_fifo.sv
// Small FIFO of requester ids, one entry per transaction granted by memory.
// Head is the id of the oldest unanswered transaction.
module obi_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  id_t           id_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output id_t           head_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    id_t           mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= ID_INSTR;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= id_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (do_pop) rptr_q <= ptr_inc(rptr_q);
            if (do_push && !do_pop) count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Shares one OBI memory port between the instruction and data requesters.
// Responses return to the issuing requester in issue order via the id FIFO.
module obi_mem_arbiter
    import obi_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    obi_req_if.slave      instr_req,
    obi_rsp_if.slave      instr_rsp,
    obi_req_if.slave      data_req,
    obi_rsp_if.slave      data_rsp,
    obi_req_if.master     mem_req,
    obi_rsp_if.master     mem_rsp,
    output logic [CW-1:0] outstanding_o,
    output logic          err_o
);

    localparam int BW = DATA_W / 8;

    logic              locked_q, locked_d;
    id_t               lock_id_q, lock_id_d;
    id_t               last_id_q, last_id_d;
    logic              err_q, err_d;

    id_t               sel;
    logic              active;
    logic              req_sel;
    logic              we_sel;
    logic [BW-1:0]     be_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              mreq;
    logic              hs;
    logic              pop;
    logic              full;
    logic              empty;
    id_t               head;

    // A stalled request keeps its requester selected until memory grants it
    always_comb begin
        sel = ID_INSTR;
        if (locked_q) sel = lock_id_q;
        else if (instr_req.req && data_req.req) sel = ~last_id_q;
        else if (data_req.req) sel = ID_DATA;
    end

    assign active = locked_q | instr_req.req | data_req.req;

    always_comb begin
        req_sel   = 1'b0;
        we_sel    = 1'b0;
        be_sel    = '0;
        addr_sel  = '0;
        wdata_sel = '0;
        if (active) begin
            if (sel == ID_DATA) begin
                req_sel   = data_req.req;
                we_sel    = data_req.we;
                be_sel    = data_req.be;
                addr_sel  = data_req.addr;
                wdata_sel = data_req.wdata;
            end else begin
                req_sel   = instr_req.req;
                we_sel    = instr_req.we;
                be_sel    = instr_req.be;
                addr_sel  = instr_req.addr;
                wdata_sel = instr_req.wdata;
            end
        end
    end

    assign mreq          = req_sel & ~full;
    assign hs            = mreq & mem_req.gnt;
    assign mem_req.req   = mreq;
    assign mem_req.we    = we_sel;
    assign mem_req.be    = be_sel;
    assign mem_req.addr  = addr_sel;
    assign mem_req.wdata = wdata_sel;

    assign instr_req.gnt = hs & (sel == ID_INSTR);
    assign data_req.gnt  = hs & (sel == ID_DATA);

    assign pop              = mem_rsp.rvalid & ~empty;
    assign instr_rsp.rvalid = pop & (head == ID_INSTR);
    assign data_rsp.rvalid  = pop & (head == ID_DATA);
    assign instr_rsp.rdata  = mem_rsp.rdata;
    assign data_rsp.rdata   = mem_rsp.rdata;

    always_comb begin
        locked_d  = locked_q;
        lock_id_d = lock_id_q;
        last_id_d = last_id_q;
        err_d     = err_q | (mem_rsp.rvalid & empty);
        if (hs) begin
            locked_d  = 1'b0;
            last_id_d = sel;
        end else if (mreq) begin
            locked_d  = 1'b1;
            lock_id_d = sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            locked_q  <= 1'b0;
            lock_id_q <= ID_INSTR;
            last_id_q <= ID_DATA;
            err_q     <= 1'b0;
        end else begin
            locked_q  <= locked_d;
            lock_id_q <= lock_id_d;
            last_id_q <= last_id_d;
            err_q     <= err_d;
        end
    end

    assign err_o = err_q;

    obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .id_i    (sel),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head),
        .count_o (outstanding_o)
    );

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Self-checking bench for obi_mem_arbiter: memory model plus response scoreboard.
// Instr addresses have bit 12 clear, data addresses have it set; rdata = addr ^ 0xDEADBFEF.
module tb_obi_mem_arbiter;
    import obi_arb_pkg::*;

    localparam int MO = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    obi_req_if #(.ADDR_W(AW), .DATA_W(DW)) ireq();
    obi_req_if #(.ADDR_W(AW), .DATA_W(DW)) dreq();
    obi_req_if #(.ADDR_W(AW), .DATA_W(DW)) mreq();
    obi_rsp_if #(.DATA_W(DW)) irsp();
    obi_rsp_if #(.DATA_W(DW)) drsp();
    obi_rsp_if #(.DATA_W(DW)) mrsp();

    logic [1:0]  outstanding;
    logic        err;

    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = 4'hF;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        m_gnt = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        spur = 1'b0;

    assign ireq.req   = i_req;
    assign ireq.we    = 1'b0;
    assign ireq.be    = 4'hF;
    assign ireq.addr  = i_addr;
    assign ireq.wdata = 32'h0;
    assign dreq.req   = d_req;
    assign dreq.we    = d_we;
    assign dreq.be    = d_be;
    assign dreq.addr  = d_addr;
    assign dreq.wdata = d_wdata;
    assign mreq.gnt   = m_gnt;
    assign mrsp.rvalid = m_rvalid | spur;
    assign mrsp.rdata  = m_rdata;

    obi_mem_arbiter #(
        .MAX_OUTSTANDING (MO),
        .ADDR_W          (AW),
        .DATA_W          (DW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .instr_req     (ireq),
        .instr_rsp     (irsp),
        .data_req      (dreq),
        .data_rsp      (drsp),
        .mem_req       (mreq),
        .mem_rsp       (mrsp),
        .outstanding_o (outstanding),
        .err_o         (err)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } mrsp_t;

    typedef struct {
        id_t         id;
        logic [31:0] data;
    } exp_t;

    mrsp_t memq[$];
    exp_t  sb[$];
    int    cyc = 0;
    int    rsp_delay = 1;
    int    pass_cnt = 0;
    int    total_cnt = 0;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a ^ 32'hDEADBFEF;
    endfunction

    function automatic id_t id_of(input logic [31:0] a);
        return a[12];
    endfunction

    // Memory: answers accepted requests in order, rsp_delay cycles after the grant
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        m_rvalid = 1'b0;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            m_rvalid = 1'b1;
            m_rdata  = memq[0].data;
            void'(memq.pop_front());
        end
    end

    // Scoreboard: push on handshake, pop and compare on routed rvalid
    always @(negedge clk) begin
        exp_t e;
        id_t  a_id;
        if (rst_n) begin
            if (irsp.rvalid || drsp.rvalid) begin
                total_cnt++;
                if (sb.size() == 0 || (irsp.rvalid && drsp.rvalid)) begin
                    $display("FAIL rsp_route: rvalid instr=%0b data=%0b pending=%0d, required one rvalid with a pending entry",
                             irsp.rvalid, drsp.rvalid, sb.size());
                end else begin
                    e = sb.pop_front();
                    if (drsp.rvalid !== e.id || irsp.rdata !== e.data)
                        $display("FAIL rsp_order: got id=%0b rdata=%h, required id=%0b rdata=%h",
                                 drsp.rvalid, irsp.rdata, e.id, e.data);
                    else
                        pass_cnt++;
                end
            end
            if (mreq.req && mreq.gnt) begin
                a_id = id_of(mreq.addr);
                memq.push_back('{rdata_of(mreq.addr), cyc + rsp_delay});
                sb.push_back('{a_id, rdata_of(mreq.addr)});
                total_cnt++;
                if (ireq.gnt !== (a_id == ID_INSTR) || dreq.gnt !== (a_id == ID_DATA))
                    $display("FAIL gnt_route: addr=%h igs=%0b dgnt=%0b, required id %0b granted",
                             mreq.addr, ireq.gnt, dreq.gnt, a_id);
                else
                    pass_cnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required bench completion");
        $fatal(1, "bench timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        spur  = 1'b0;
        memq.delete();
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (memq.size() == 0 && sb.size() == 0 && !m_rvalid) break;
        end
        total_cnt++;
        if (sb.size() != 0 || outstanding !== 2'd0)
            $display("FAIL drain: pending=%0d outstanding=%0d, required 0/0", sb.size(), outstanding);
        else
            pass_cnt++;
        step();
    endtask

    task automatic test_reset();
        i_req = 1'b0;
        d_req = 1'b0;
        m_gnt = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({ireq.gnt, dreq.gnt, irsp.rvalid, drsp.rvalid, mreq.req} !== 5'b0)
            $display("FAIL reset_ctl: gnt/rvalid/req=%b, required 00000",
                     {ireq.gnt, dreq.gnt, irsp.rvalid, drsp.rvalid, mreq.req});
        else
            pass_cnt++;
        total_cnt++;
        if ({mreq.addr, mreq.wdata, mreq.be, mreq.we} !== '0)
            $display("FAIL reset_mux: addr=%h wdata=%h be=%h we=%b, required all zero",
                     mreq.addr, mreq.wdata, mreq.be, mreq.we);
        else
            pass_cnt++;
        total_cnt++;
        if (outstanding !== 2'd0 || err !== 1'b0)
            $display("FAIL reset_state: outstanding=%0d err=%b, required 0/0", outstanding, err);
        else
            pass_cnt++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alternate();
        rsp_delay = 1;
        i_addr = 32'h0000_0200;
        d_addr = 32'h0000_1300;
        d_we   = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        m_gnt  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total_cnt++;
            if (ireq.gnt !== (c % 2 == 0) || dreq.gnt !== (c % 2 == 1))
                $display("FAIL alternate c%0d: igs=%0b dgnt=%0b, required instr=%0b",
                         c, ireq.gnt, dreq.gnt, (c % 2 == 0));
            else
                pass_cnt++;
            step();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        drain();
    endtask

    task automatic test_single();
        rsp_delay = 1;
        i_addr = 32'h0000_0100;
        i_req  = 1'b1;
        m_gnt  = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (ireq.gnt !== 1'b1 || dreq.gnt !== 1'b0 || mreq.addr !== 32'h100)
            $display("FAIL single_gnt: igs=%0b dgnt=%0b addr=%h, required 1/0/00000100",
                     ireq.gnt, dreq.gnt, mreq.addr);
        else
            pass_cnt++;
        step();
        i_req = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (irsp.rvalid !== 1'b1 || irsp.rdata !== 32'hDEADBEEF || drsp.rvalid !== 1'b0)
            $display("FAIL single_rsp: irv=%0b rdata=%h drv=%0b, required 1/deadbeef/0",
                     irsp.rvalid, irsp.rdata, drsp.rvalid);
        else
            pass_cnt++;
        drain();
    endtask

    task automatic test_lock();
        do_reset();
        rsp_delay = 1;
        d_addr  = 32'h0000_1340;
        d_we    = 1'b1;
        d_be    = 4'b0011;
        d_wdata = 32'hCAFE_F00D;
        i_addr  = 32'h0000_0240;
        d_req   = 1'b1;
        m_gnt   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) i_req = 1'b1;
            if (c == 3) m_gnt = 1'b1;
            @(negedge clk);
            total_cnt++;
            if (mreq.addr !== 32'h1340 || ireq.gnt !== 1'b0 || dreq.gnt !== (c == 3))
                $display("FAIL lock c%0d: addr=%h igs=%0b dgnt=%0b, required 00001340/0/%0b",
                         c, mreq.addr, ireq.gnt, dreq.gnt, (c == 3));
            else
                pass_cnt++;
            if (c == 0) begin
                total_cnt++;
                if (mreq.we !== 1'b1 || mreq.be !== 4'b0011 || mreq.wdata !== 32'hCAFEF00D)
                    $display("FAIL lock_fwd: we=%b be=%b wdata=%h, required 1/0011/cafef00d",
                             mreq.we, mreq.be, mreq.wdata);
                else
                    pass_cnt++;
            end
            step();
        end
        d_req = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (ireq.gnt !== 1'b1 || mreq.addr !== 32'h240)
            $display("FAIL lock_next: igs=%0b addr=%h, required 1/00000240", ireq.gnt, mreq.addr);
        else
            pass_cnt++;
        step();
        i_req = 1'b0;
        d_we  = 1'b0;
        d_be  = 4'hF;
        drain();
    endtask

    task automatic test_full();
        logic exp_req;
        logic exp_rv;
        logic [1:0] exp_out;
        logic [1:0] out_tab [7];
        out_tab = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
        rsp_delay = 5;
        m_gnt  = 1'b1;
        i_addr = 32'h0000_0400;
        i_req  = 1'b1;
        for (int c = 0; c < 7; c++) begin
            exp_req = (c < 2) || (c == 6);
            exp_rv  = (c >= 5);
            exp_out = out_tab[c];
            @(negedge clk);
            total_cnt++;
            if (mreq.req !== exp_req || ireq.gnt !== exp_req)
                $display("FAIL full_req c%0d: req=%0b gnt=%0b, required %0b", c, mreq.req, ireq.gnt, exp_req);
            else
                pass_cnt++;
            total_cnt++;
            if (outstanding !== exp_out || irsp.rvalid !== exp_rv)
                $display("FAIL full_cnt c%0d: outstanding=%0d rvalid=%0b, required %0d/%0b",
                         c, outstanding, irsp.rvalid, exp_out, exp_rv);
            else
                pass_cnt++;
            step();
            if (exp_req) i_addr = i_addr + 32'h4;
        end
        i_req = 1'b0;
        drain();
        rsp_delay = 1;
    endtask

    task automatic test_pushpop();
        logic [1:0] out_tab [4];
        out_tab = '{2'd0, 2'd1, 2'd1, 2'd0};
        rsp_delay = 1;
        m_gnt  = 1'b1;
        i_addr = 32'h0000_0180;
        d_addr = 32'h0000_1380;
        i_req  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total_cnt++;
            if (outstanding !== out_tab[c])
                $display("FAIL pushpop_cnt c%0d: outstanding=%0d, required %0d", c, outstanding, out_tab[c]);
            else
                pass_cnt++;
            if (c == 1) begin
                total_cnt++;
                if (dreq.gnt !== 1'b1 || irsp.rvalid !== 1'b1)
                    $display("FAIL pushpop_both: dgnt=%0b irv=%0b, required 1/1", dreq.gnt, irsp.rvalid);
                else
                    pass_cnt++;
            end
            step();
            i_req = 1'b0;
            d_req = (c == 0);
        end
        drain();
    endtask

    task automatic test_spurious();
        m_gnt = 1'b0;
        spur  = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (err !== 1'b0 || irsp.rvalid !== 1'b0 || drsp.rvalid !== 1'b0)
            $display("FAIL spur_now: err=%0b irv=%0b drv=%0b, required 0/0/0", err, irsp.rvalid, drsp.rvalid);
        else
            pass_cnt++;
        step();
        spur = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if (err !== 1'b1)
                $display("FAIL spur_sticky c%0d: err=%0b, required 1", c, err);
            else
                pass_cnt++;
            step();
        end
        do_reset();
        @(negedge clk);
        total_cnt++;
        if (err !== 1'b0)
            $display("FAIL spur_clear: err=%0b, required 0", err);
        else
            pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_single();
        test_lock();
        test_full();
        test_pushpop();
        test_spurious();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
